// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
//   Request/result bundle for the bit-serial adder controller.
//   master : drives start, a, b, cin; observes busy, done, sum, cout
//   slave  : the adder itself (inverse directions)
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Computes {cout,sum} = a + b + cin one bit per clock, LSB first, through a
//   single 1-bit full-adder slice. An operation takes WIDTH RUN cycles and one
//   DONE cycle; start is honoured only in IDLE.
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_add_ctrl_if
//            start/a/b/cin in, busy/done/sum/cout out
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_add_ctrl_if.slave     bus
);

  // WIDTH >= 2, so this is at least 1 and holds WIDTH-1 without wrapping.
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // operand A shift register
  logic [WIDTH-1:0] b_q, b_d;        // operand B shift register
  logic             c_q, c_d;        // carry between slice evaluations
  logic [WIDTH-1:0] psum_q, psum_d;  // partial sum, filled from the MSB side
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // The one full-adder slice shared by every bit position.
  logic slice_s, slice_co;
  always_comb begin
    slice_s  = a_q[0] ^ b_q[0] ^ c_q;
    slice_co = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // After WIDTH right-shifts bit 0 of the result has reached the LSB.
        psum_d = {slice_s, psum_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = slice_co;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = {slice_s, psum_q[WIDTH-1:1]};
          cout_d  = slice_co;
          cnt_d   = cnt_q;
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real registers do.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl at WIDTH=8. Expected results come
//   from a table of hand-computed vectors and, for random operands, from plain
//   (WIDTH+1)-bit addition. Timing expectations follow the operation contract:
//   start accepted at edge n, busy through edge n+WIDTH, done for one cycle.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [W-1:0] ref_sum;   // result the DUT should currently be showing
  logic         ref_cout;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation. Inputs are scrambled during RUN to show they are
  // not re-sampled. With hold=1 start stays high through RUN and the DONE
  // cycle and is left high on return, modelling a continuously held request.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [W-1:0] exp_sum,
                       input logic exp_cout, input bit hold, input string tag);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    check({tag, " idle before start"}, {31'd0, bus.busy}, 32'd0);
    tick();                                   // edge n: accepted
    for (int k = 0; k < W; k++) begin
      check({tag, " busy in run"}, {31'd0, bus.busy}, 32'd1);
      check({tag, " no done in run"}, {31'd0, bus.done}, 32'd0);
      check({tag, " sum holds in run"}, {23'd0, bus.cout, bus.sum},
            {23'd0, ref_cout, ref_sum});
      bus.start = hold;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      tick();
    end
    // Now between edges n+W and n+W+1.
    check({tag, " done pulse"}, {31'd0, bus.done}, 32'd1);
    check({tag, " busy in done"}, {31'd0, bus.busy}, 32'd1);
    check({tag, " sum"}, {24'd0, bus.sum}, {24'd0, exp_sum});
    check({tag, " cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
    ref_sum  = exp_sum;
    ref_cout = exp_cout;
    tick();                                   // start (if held) ignored here
    check({tag, " idle after done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
    check({tag, " result held"}, {23'd0, bus.cout, bus.sum}, {23'd0, exp_cout, exp_sum});
  endtask

  vec_t vecs[6];

  initial begin
    logic [W:0] full;
    logic [W-1:0] ra, rb;
    logic         rc;

    n_checks = 0;
    n_fail   = 0;
    ref_sum  = '0;
    ref_cout = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b1;             // must be ignored while rst is high
    bus.a     = 8'hA5;
    bus.b     = 8'h5A;
    bus.cin   = 1'b1;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    // Reset state, with start asserted alongside rst.
    tick();
    tick();
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset sum",  {24'd0, bus.sum}, 32'd0);
    check("reset cout", {31'd0, bus.cout}, 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    check("start with rst ignored", {31'd0, bus.busy}, 32'd0);

    // Directed table.
    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
            1'b0, $sformatf("vec%0d", i));

    // start held continuously: each accept happens only from IDLE, the start
    // seen during DONE is dropped and the following edge is the next accept.
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, "hold0");
    do_op(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b1, "hold1");
    bus.start = 1'b0;
    tick();

    // Random operands against plain arithmetic.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, full[W-1:0], full[W], 1'b0, $sformatf("rand%0d", i));
    end

    // Reset at the 4th RUN edge aborts the operation.
    do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "pre_abort");
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.b     = 8'h44;
    bus.cin   = 1'b0;
    tick();                       // edge n
    bus.start = 1'b0;
    tick();                       // RUN edge 1
    tick();                       // RUN edge 2
    tick();                       // RUN edge 3
    check("abort busy before rst", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();                       // RUN edge 4 with rst
    rst = 1'b0;
    ref_sum  = '0;
    ref_cout = 1'b0;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort sum",  {24'd0, bus.sum}, 32'd0);
    check("abort cout", {31'd0, bus.cout}, 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      check("abort no done", {31'd0, bus.done}, 32'd0);
      tick();
    end
    do_op(8'hA0, 8'h0B, 1'b1, 8'hAC, 1'b0, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time bound in case the clock or a task stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request to begin an addition; accepted only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 Port: cin  input  1  carry-in, captured when start is accepted.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: sum  output  WIDTH  result register.
REQ-011 Port: cout  output  1  final carry-out register.

Function
REQ-012 Block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder slice: s = x^y^c, co = x&y | c&(x^y).
REQ-013 FSM states SHALL be IDLE, RUN and DONE; no other reachable states.
REQ-014 IDLE: when start=1 at edge n, capture a, b, cin into internal shift and carry registers, clear the bit counter, and go to RUN.
REQ-015 IDLE with start=0: remain in IDLE; sum and cout hold.
REQ-016 RUN: each edge SHALL feed operand bit[0] and the carry flop to the slice, shift the slice output into the MSB of the partial-sum shift register, shift the operands right, and store the slice carry.
REQ-017 RUN SHALL last exactly WIDTH edges (counter 0..WIDTH-1); on the WIDTH-th edge (edge n+WIDTH), load sum and cout from the completed result and go to DONE.
REQ-018 DONE: done=1 for exactly the cycle between edges n+WIDTH and n+WIDTH+1, then unconditional return to IDLE.
REQ-019 Latency: start sampled at edge n gives a valid result and done=1 after edge n+WIDTH; the earliest next accepted start is at edge n+WIDTH+2.
REQ-020 start SHALL be ignored in RUN and DONE, including on the DONE cycle; operands are not re-captured and no error is flagged.
REQ-021 Changes on a, b or cin after capture SHALL NOT affect the in-flight result.
REQ-022 sum and cout SHALL change only at the completing edge (REQ-017) or on reset; they hold through RUN and IDLE, so the previous result stays visible during a new operation.
REQ-023 Overflow: cout SHALL be the true carry out of bit WIDTH-1; sum wraps modulo 2^WIDTH.
REQ-024 Bit counter width SHALL be ceil(log2(WIDTH)) bits or more, with no wrap-around before the terminal count.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, sum=0, cout=0, the counter to 0, and the internal shift and carry registers to 0.
REQ-026 Reset SHALL take priority over start and over any in-flight RUN or DONE state; an aborted operation produces no done pulse and does not update sum or cout.
REQ-027 start=1 in the same cycle as rst=1 SHALL be ignored; the first acceptable start is at the edge after rst is deasserted.

Verification (WIDTH=8)
REQ-028 a=0x5A, b=0x3C, cin=0, start pulse -> after 8 RUN edges: done=1 for one cycle, sum=0x96, cout=0, busy high for 9 cycles.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, carry ripples through all 8 bits.
REQ-030 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, and sum holds 0xFF throughout the second RUN.
REQ-031 start held high continuously with a changed mid-RUN -> only the first operands are used; done pulses once per 10 cycles, with starts accepted only in IDLE.
REQ-032 rst asserted at the 4th RUN edge -> busy=0, sum=0, cout=0, no done pulse; a fresh start then completes normally.
REQ-033 start asserted exactly on the DONE cycle -> ignored, and the FSM returns to IDLE; start on the next cycle is accepted.
